// File: rtl/misc_result_accum.sv
// misc_result_accum: collects ACC_LEN XOUT samples per frame and reports the frame's sum, max and count
//   clk, rst_n        clock and async active-low reset
//   i_in_valid/o_in_ready/i_xout   sample input handshake and data
//   i_flush           closes a partial frame (ignored while a result is pending)
//   o_out_valid/i_out_ready        frame result handshake
//   o_out_sum/o_out_max/o_out_cnt  frame sum, largest sample, sample count
module misc_result_accum #(
  parameter int NX = 8,
  parameter int ACC_LEN = 4,
  parameter int ACCW = NX + $clog2(ACC_LEN)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_in_valid,
  output logic                     o_in_ready,
  input  logic [NX-1:0]            i_xout,
  input  logic                     i_flush,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic [ACCW-1:0]          o_out_sum,
  output logic [NX-1:0]            o_out_max,
  output logic [$clog2(ACC_LEN):0] o_out_cnt
);
  localparam int CW = $clog2(ACC_LEN) + 1;
  typedef enum logic {S_ACC, S_HOLD} state_t;
  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [ACCW-1:0] r_sum;
  logic [NX-1:0]   r_max;
  logic            r_out_valid;
  logic [ACCW-1:0] r_out_sum;
  logic [NX-1:0]   r_out_max;
  logic [CW-1:0]   r_out_cnt;
  logic            w_accept;
  logic            w_emit;
  logic            w_close;
  logic [CW-1:0]   w_cnt_nxt;
  logic [ACCW-1:0] w_sum_nxt;
  logic [NX-1:0]   w_max_nxt;
  // HOLD acts as a pass-through slot: a sample enters only when the pending frame leaves
  always_comb begin
    o_in_ready = (r_state == S_ACC) | i_out_ready;
    w_accept   = i_in_valid & o_in_ready;
    w_emit     = r_out_valid & i_out_ready;
    w_cnt_nxt  = r_cnt + CW'(w_accept);
    w_sum_nxt  = r_sum + (w_accept ? ACCW'(i_xout) : '0);
    w_max_nxt  = (w_accept && i_xout > r_max) ? i_xout : r_max;
    w_close    = (w_cnt_nxt == CW'(ACC_LEN)) | (i_flush & (w_cnt_nxt != '0));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_ACC;
      r_cnt       <= '0;
      r_sum       <= '0;
      r_max       <= '0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_max   <= '0;
      r_out_cnt   <= '0;
    end else if (r_state == S_ACC && w_close) begin
      r_out_sum   <= w_sum_nxt;
      r_out_max   <= w_max_nxt;
      r_out_cnt   <= w_cnt_nxt;
      r_out_valid <= 1'b1;
      r_cnt       <= '0;
      r_sum       <= '0;
      r_max       <= '0;
      r_state     <= S_HOLD;
    end else if (r_state == S_ACC || w_emit) begin
      // accumulators are zero in HOLD, so an accept on emit starts the new frame at that sample
      r_cnt       <= w_cnt_nxt;
      r_sum       <= w_sum_nxt;
      r_max       <= w_max_nxt;
      r_out_valid <= 1'b0;
      r_state     <= S_ACC;
    end
  end
  assign o_out_valid = r_out_valid;
  assign o_out_sum   = r_out_sum;
  assign o_out_max   = r_out_max;
  assign o_out_cnt   = r_out_cnt;
endmodule

// File: tb/tb_misc_result_accum.sv
// tb_misc_result_accum: scoreboard bench for misc_result_accum with directed and random traffic
module tb_misc_result_accum;
  localparam int NX = 8;
  localparam int ACC_LEN = 4;
  localparam int ACCW = NX + $clog2(ACC_LEN);
  typedef struct {int sum; int mx; int cnt;} frame_t;
  logic clk = 0;
  logic rst_n = 0;
  logic i_in_valid = 0;
  logic o_in_ready;
  logic [NX-1:0] i_xout = 0;
  logic i_flush = 0;
  logic o_out_valid;
  logic i_out_ready = 0;
  logic [ACCW-1:0] o_out_sum;
  logic [NX-1:0] o_out_max;
  logic [$clog2(ACC_LEN):0] o_out_cnt;
  int n_chk = 0;
  int n_pass = 0;
  int n_frames = 0;
  bit mon_en = 0;
  bit m_pend = 0;
  bit exp_valid = 0;
  bit exp_in_ready = 1;
  int frame[$];
  frame_t sb[$];
  misc_result_accum dut (
    .clk(clk), .rst_n(rst_n), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .i_xout(i_xout), .i_flush(i_flush), .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
    .o_out_sum(o_out_sum), .o_out_max(o_out_max), .o_out_cnt(o_out_cnt)
  );
  always #5 clk = ~clk;
  function automatic void chk(string n, int a, int e);
    n_chk++;
    if (a == e) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d at %0t", n, a, e, $time);
  endfunction
  // one clock of stimulus; the reference model advances to the state after the coming edge
  task automatic step(input bit v, input int x, input bit f, input bit r);
    bit acc;
    bit was_pend;
    frame_t fr;
    @(posedge clk);
    #1;
    i_in_valid = v;
    i_xout = x[NX-1:0];
    i_flush = f;
    i_out_ready = r;
    was_pend = m_pend;
    exp_valid = m_pend;
    exp_in_ready = !m_pend || r;
    acc = v && exp_in_ready;
    if (m_pend && r) m_pend = 0;
    if (acc) frame.push_back(x & 8'hff);
    if (!was_pend && (frame.size() == ACC_LEN || (f && frame.size() > 0))) begin
      fr.sum = 0;
      fr.mx = 0;
      foreach (frame[i]) begin
        fr.sum += frame[i];
        if (frame[i] > fr.mx) fr.mx = frame[i];
      end
      fr.cnt = frame.size();
      sb.push_back(fr);
      frame.delete();
      m_pend = 1;
    end
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 1);
  endtask
  task automatic chk_reset_outs();
    chk("rst_out_valid", o_out_valid, 0);
    chk("rst_out_sum", o_out_sum, 0);
    chk("rst_out_max", o_out_max, 0);
    chk("rst_out_cnt", o_out_cnt, 0);
  endtask
  always @(negedge clk) begin
    if (mon_en) begin
      chk("in_ready", o_in_ready, exp_in_ready);
      chk("out_valid", o_out_valid, exp_valid);
      if (o_out_valid) begin
        if (sb.size() == 0) chk("unexpected_frame", 1, 0);
        else begin
          chk("out_sum", o_out_sum, sb[0].sum);
          chk("out_max", o_out_max, sb[0].mx);
          chk("out_cnt", o_out_cnt, sb[0].cnt);
          if (i_out_ready) begin
            sb.pop_front();
            n_frames++;
          end
        end
      end
    end
  end
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outs();
    rst_n = 1;
    mon_en = 1;
    step(1, 10, 0, 1); step(1, 20, 0, 1); step(1, 30, 0, 1); step(1, 40, 0, 1);
    idle(3);
    for (int i = 0; i < 4; i++) step(1, 255, 0, 1);
    idle(2);
    step(1, 7, 0, 1); step(1, 3, 0, 1); step(0, 0, 1, 1);
    idle(2);
    step(0, 0, 1, 1);
    idle(2);
    for (int i = 0; i < 4; i++) step(1, i + 5, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 100 + i, i == 2, 0);
    step(1, 9, 0, 1);
    step(1, 1, 0, 1); step(1, 1, 0, 1); step(1, 1, 0, 1);
    idle(2);
    step(1, 1, 0, 1); step(1, 2, 0, 1); step(1, 50, 1, 1);
    idle(2);
    step(1, 60, 0, 1); step(1, 70, 0, 1);
    @(posedge clk);
    #1;
    mon_en = 0;
    rst_n = 0;
    i_in_valid = 0;
    #1;
    chk_reset_outs();
    frame.delete();
    sb.delete();
    m_pend = 0;
    exp_valid = 0;
    exp_in_ready = 1;
    repeat (2) @(negedge clk);
    chk_reset_outs();
    @(posedge clk);
    #1;
    rst_n = 1;
    mon_en = 1;
    for (int i = 0; i < 4; i++) step(1, 1, 0, 1);
    idle(2);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(3, 0) != 0, $urandom_range(255, 0), $urandom_range(7, 0) == 0, $urandom_range(3, 0) != 0);
    idle(6);
    chk("scoreboard_drained", sb.size(), 0);
    chk("frames_seen", int'(n_frames > 100), 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
